// File: rtl/falling_char_engine.sv
// falling_char_engine: slot table of falling characters for the typing game.
// Spawns characters, moves them down one row per fall tick, and retires them
// on a key match or when they drop past the bottom row. All table changes are
// mirrored to video RAM through a single registered cell-write stream.
// Optional feature macro: FCE_MULTI_HIT_EN (characters need 1..3 key hits and
// the cell color tracks the hits left; otherwise every match retires at once).
module falling_char_engine #(
    parameter int SLOTS      = 32,
    parameter int COLS       = 70,
    parameter int TOP_ROW    = 2,
    parameter int BOTTOM_ROW = 27,
    parameter int ADDR_W     = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spawn_tick,
    input  logic [7:0]        spawn_char,
    input  logic [6:0]        spawn_col,
    input  logic [1:0]        spawn_hits,
    input  logic              fall_tick,
    input  logic              key_valid,
    input  logic [7:0]        key_code,
    output logic              key_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [10:0]       wr_data,
    output logic [9:0]        hit_score,
    output logic [9:0]        miss_score,
    output logic              hit_evt,
    output logic              miss_evt,
    output logic [6:0]        evt_col,
    output logic              spawn_drop
);
    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int ROW_W = $clog2(BOTTOM_ROW + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SLOTS - 1);
    localparam logic [ROW_W-1:0] TOP_R     = ROW_W'(TOP_ROW);
    localparam logic [ROW_W-1:0] BOTTOM_R  = ROW_W'(BOTTOM_ROW);
    localparam logic [9:0]       SCORE_MAX = 10'd999;

    typedef enum logic [2:0] {
        IDLE,
        KEY_SCAN,
        FALL_SCAN,
        FALL_WR,
        SPAWN
    } state_t;

    state_t state, next_state;

    // slot table
    logic [SLOTS-1:0] slot_active;
    logic [7:0]       slot_char [SLOTS];
    logic [6:0]       slot_col  [SLOTS];
    logic [ROW_W-1:0] slot_row  [SLOTS];
`ifdef FCE_MULTI_HIT_EN
    logic [1:0]       slot_hits [SLOTS];
    logic [1:0]       spawn_hits_buf;
    logic [1:0]       cur_hits;
    logic             op_dec;
`else
    logic             unused_spawn_hits;
`endif

    // request latches
    logic       key_pend, fall_pend, spawn_pend;
    logic [7:0] key_buf;
    logic [7:0] spawn_char_buf;
    logic [6:0] spawn_col_buf;

    // scan cursor and control
    logic [IDX_W-1:0] idx;
    logic             idx_clr, idx_inc;
    logic             key_done, fall_done, spawn_done;
    logic             op_clr, op_down, op_spawn;
    logic             wr_en_n, hit_n, miss_n, drop_n;
    logic [ADDR_W-1:0] wr_addr_n;
    logic [10:0]       wr_data_n;

    // current slot view
    logic              cur_active;
    logic [7:0]        cur_char;
    logic [6:0]        cur_col;
    logic [ROW_W-1:0]  cur_row;
    logic [2:0]        cur_color;
    logic [1:0]        spawn_hits_eff;
    logic [ADDR_W-1:0] cur_addr, down_addr, spawn_addr;
    logic              spawn_col_ok;

    // lowest free slot
    logic             free_found;
    logic [IDX_W-1:0] free_idx;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                    input logic [6:0] c);
        return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
    endfunction

    assign cur_active = slot_active[idx];
    assign cur_char   = slot_char[idx];
    assign cur_col    = slot_col[idx];
    assign cur_row    = slot_row[idx];
    assign cur_addr   = cell_addr(cur_row, cur_col);
    assign down_addr  = cell_addr(cur_row + ROW_W'(1), cur_col);
    assign spawn_addr = cell_addr(TOP_R, spawn_col_buf);
    assign spawn_col_ok = 32'(spawn_col_buf) < 32'(COLS);
    assign key_ready  = ~key_pend;

`ifdef FCE_MULTI_HIT_EN
    assign cur_hits       = slot_hits[idx];
    assign cur_color      = {1'b0, cur_hits};
    assign spawn_hits_eff = spawn_hits_buf;
`else
    assign cur_color         = 3'b001;
    assign spawn_hits_eff    = 2'd1;
    assign unused_spawn_hits = ^spawn_hits;
`endif

    // priority encoder: scan downward so the lowest free index wins
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = SLOTS; i > 0; i--) begin
            if (!slot_active[i-1]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i - 1);
            end
        end
    end

    // state and scan cursor registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= next_state;
            if (idx_clr)
                idx <= '0;
            else if (idx_inc)
                idx <= idx + IDX_W'(1);
        end
    end

    // next state, table operations and next output values
    always_comb begin
        next_state = state;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        key_done   = 1'b0;
        fall_done  = 1'b0;
        spawn_done = 1'b0;
        op_clr     = 1'b0;
        op_down    = 1'b0;
        op_spawn   = 1'b0;
`ifdef FCE_MULTI_HIT_EN
        op_dec     = 1'b0;
`endif
        wr_en_n    = 1'b0;
        wr_addr_n  = '0;
        wr_data_n  = '0;
        hit_n      = 1'b0;
        miss_n     = 1'b0;
        drop_n     = 1'b0;
        case (state)
            IDLE: begin
                idx_clr = 1'b1;
                if (key_pend)
                    next_state = KEY_SCAN;
                else if (fall_pend)
                    next_state = FALL_SCAN;
                else if (spawn_pend)
                    next_state = SPAWN;
            end
            KEY_SCAN: begin
                if (cur_active && cur_char == key_buf) begin
                    wr_en_n    = 1'b1;
                    wr_addr_n  = cur_addr;
                    key_done   = 1'b1;
                    next_state = IDLE;
`ifdef FCE_MULTI_HIT_EN
                    if (cur_hits > 2'd1) begin
                        op_dec    = 1'b1;
                        wr_data_n = {1'b0, cur_hits - 2'd1, cur_char};
                    end else begin
                        op_clr = 1'b1;
                        hit_n  = 1'b1;
                    end
`else
                    op_clr = 1'b1;
                    hit_n  = 1'b1;
`endif
                end else if (idx == LAST_IDX) begin
                    key_done   = 1'b1;
                    next_state = IDLE;
                end else begin
                    idx_inc = 1'b1;
                end
            end
            FALL_SCAN: begin
                if (cur_active) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = cur_addr;
                end
                if (cur_active && cur_row != BOTTOM_R) begin
                    next_state = FALL_WR;
                end else begin
                    if (cur_active) begin
                        op_clr = 1'b1;
                        miss_n = 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        fall_done  = 1'b1;
                        next_state = IDLE;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            FALL_WR: begin
                op_down   = 1'b1;
                wr_en_n   = 1'b1;
                wr_addr_n = down_addr;
                wr_data_n = {cur_color, cur_char};
                if (idx == LAST_IDX) begin
                    fall_done  = 1'b1;
                    next_state = IDLE;
                end else begin
                    idx_inc    = 1'b1;
                    next_state = FALL_SCAN;
                end
            end
            SPAWN: begin
                spawn_done = 1'b1;
                next_state = IDLE;
                if (free_found && spawn_col_ok) begin
                    op_spawn  = 1'b1;
                    wr_en_n   = 1'b1;
                    wr_addr_n = spawn_addr;
                    wr_data_n = {1'b0, spawn_hits_eff, spawn_char_buf};
                end else begin
                    drop_n = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // request latches; a tick arriving while its latch is set merges into it
    always_ff @(posedge clk) begin
        if (rst) begin
            key_pend       <= 1'b0;
            fall_pend      <= 1'b0;
            spawn_pend     <= 1'b0;
            key_buf        <= '0;
            spawn_char_buf <= '0;
            spawn_col_buf  <= '0;
`ifdef FCE_MULTI_HIT_EN
            spawn_hits_buf <= 2'd1;
`endif
        end else begin
            if (key_done)
                key_pend <= 1'b0;
            else if (key_valid && !key_pend) begin
                key_pend <= 1'b1;
                key_buf  <= key_code;
            end
            if (fall_done)
                fall_pend <= 1'b0;
            else if (fall_tick)
                fall_pend <= 1'b1;
            if (spawn_done)
                spawn_pend <= 1'b0;
            else if (spawn_tick && !spawn_pend) begin
                spawn_pend     <= 1'b1;
                spawn_char_buf <= spawn_char;
                spawn_col_buf  <= spawn_col;
`ifdef FCE_MULTI_HIT_EN
                spawn_hits_buf <= (spawn_hits == 2'd0) ? 2'd1 : spawn_hits;
`endif
            end
        end
    end

    // slot occupancy flags
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_active <= '0;
        end else begin
            if (op_clr)
                slot_active[idx] <= 1'b0;
            if (op_spawn)
                slot_active[free_idx] <= 1'b1;
        end
    end

    // slot payload fields; only meaningful while the slot is active
    always_ff @(posedge clk) begin
        if (op_spawn) begin
            slot_char[free_idx] <= spawn_char_buf;
            slot_col[free_idx]  <= spawn_col_buf;
            slot_row[free_idx]  <= TOP_R;
`ifdef FCE_MULTI_HIT_EN
            slot_hits[free_idx] <= spawn_hits_eff;
`endif
        end
        if (op_down)
            slot_row[idx] <= cur_row + ROW_W'(1);
`ifdef FCE_MULTI_HIT_EN
        if (op_dec)
            slot_hits[idx] <= cur_hits - 2'd1;
`endif
    end

    // registered write stream, events and saturating scores
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            hit_evt    <= 1'b0;
            miss_evt   <= 1'b0;
            spawn_drop <= 1'b0;
            evt_col    <= '0;
            hit_score  <= '0;
            miss_score <= '0;
        end else begin
            wr_en      <= wr_en_n;
            hit_evt    <= hit_n;
            miss_evt   <= miss_n;
            spawn_drop <= drop_n;
            if (wr_en_n) begin
                wr_addr <= wr_addr_n;
                wr_data <= wr_data_n;
            end
            if (hit_n || miss_n)
                evt_col <= cur_col;
            if (hit_n && hit_score != SCORE_MAX)
                hit_score <= hit_score + 10'd1;
            if (miss_n && miss_score != SCORE_MAX)
                miss_score <= miss_score + 10'd1;
        end
    end

endmodule

// File: tb/tb_falling_char_engine.sv
// Testbench for falling_char_engine: operation-level model of the slot table
// producing the expected write stream and retire events, checked in order by
// one compare process, plus literal checks of the directed scenarios.
module tb_falling_char_engine;
    localparam int SLOTS      = 32;
    localparam int COLS       = 70;
    localparam int TOP_ROW    = 2;
    localparam int BOTTOM_ROW = 27;
    localparam int ADDR_W     = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              spawn_tick;
    logic [7:0]        spawn_char;
    logic [6:0]        spawn_col;
    logic [1:0]        spawn_hits;
    logic              fall_tick;
    logic              key_valid;
    logic [7:0]        key_code;
    logic              key_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [10:0]       wr_data;
    logic [9:0]        hit_score;
    logic [9:0]        miss_score;
    logic              hit_evt;
    logic              miss_evt;
    logic [6:0]        evt_col;
    logic              spawn_drop;

    falling_char_engine #(
        .SLOTS(SLOTS), .COLS(COLS), .TOP_ROW(TOP_ROW),
        .BOTTOM_ROW(BOTTOM_ROW), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst),
        .spawn_tick(spawn_tick), .spawn_char(spawn_char),
        .spawn_col(spawn_col), .spawn_hits(spawn_hits),
        .fall_tick(fall_tick), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .hit_score(hit_score), .miss_score(miss_score),
        .hit_evt(hit_evt), .miss_evt(miss_evt), .evt_col(evt_col),
        .spawn_drop(spawn_drop)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;
    int drop_seen = 0;

    // model state
    bit m_active [SLOTS];
    int m_char [SLOTS];
    int m_col  [SLOTS];
    int m_row  [SLOTS];
    int m_hits [SLOTS];
    int m_hit, m_miss;

    int exp_addr[$], exp_data[$], exp_kind[$], exp_col[$];
    int log_addr[$], log_data[$];

    function void check(string name, int act, int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
        end
    endfunction

    function int addr_of(int r, int c);
        return r * COLS + c;
    endfunction

    function void push_wr(int a, int d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endfunction

    function void push_evt(int k, int c);
        exp_kind.push_back(k);
        exp_col.push_back(c);
    endfunction

    function void m_reset();
        for (int i = 0; i < SLOTS; i++) m_active[i] = 1'b0;
        m_hit = 0;
        m_miss = 0;
        exp_addr.delete(); exp_data.delete();
        exp_kind.delete(); exp_col.delete();
    endfunction

    // key: first active slot with that code takes one hit
    function void m_key(int code);
        for (int i = 0; i < SLOTS; i++) begin
            if (m_active[i] && m_char[i] == code) begin
                if (m_hits[i] > 1) begin
                    m_hits[i]--;
                    push_wr(addr_of(m_row[i], m_col[i]), m_hits[i] * 256 + m_char[i]);
                end else begin
                    m_active[i] = 1'b0;
                    push_wr(addr_of(m_row[i], m_col[i]), 0);
                    if (m_hit < 999) m_hit++;
                    push_evt(0, m_col[i]);
                end
                return;
            end
        end
    endfunction

    // fall: every character moves down one row or retires past the bottom
    function void m_fall();
        for (int i = 0; i < SLOTS; i++) begin
            if (m_active[i]) begin
                push_wr(addr_of(m_row[i], m_col[i]), 0);
                if (m_row[i] == BOTTOM_ROW) begin
                    m_active[i] = 1'b0;
                    if (m_miss < 999) m_miss++;
                    push_evt(1, m_col[i]);
                end else begin
                    m_row[i]++;
                    push_wr(addr_of(m_row[i], m_col[i]), m_hits[i] * 256 + m_char[i]);
                end
            end
        end
    endfunction

    function void m_spawn(int ch, int col, int h);
        int hh;
        int slot;
`ifdef FCE_MULTI_HIT_EN
        hh = (h == 0) ? 1 : h;
`else
        hh = 1;
        if (h < 0) hh = 0;
`endif
        slot = -1;
        for (int i = SLOTS - 1; i >= 0; i--) if (!m_active[i]) slot = i;
        if (col >= COLS || slot < 0) begin
            push_evt(2, 0);
        end else begin
            m_active[slot] = 1'b1;
            m_char[slot] = ch;
            m_col[slot]  = col;
            m_row[slot]  = TOP_ROW;
            m_hits[slot] = hh;
            push_wr(addr_of(TOP_ROW, col), hh * 256 + ch);
        end
    endfunction

    // compare process: write stream and events in order against the model
    always @(negedge clk) begin
        int a, d, k, c, n, kind;
        if (checking) begin
            if (wr_en) begin
                log_addr.push_back(int'(wr_addr));
                log_data.push_back(int'(wr_data));
                if (exp_addr.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL wr_unexpected: addr %0d data 0x%0h, no write required", wr_addr, wr_data);
                end else begin
                    a = exp_addr.pop_front();
                    d = exp_data.pop_front();
                    check("wr_addr", int'(wr_addr), a);
                    check("wr_data", int'(wr_data), d);
                end
            end
            n = int'(hit_evt) + int'(miss_evt) + int'(spawn_drop);
            if (n > 1) check("evt_single", n, 1);
            if (n >= 1) begin
                kind = hit_evt ? 0 : (miss_evt ? 1 : 2);
                if (spawn_drop) drop_seen++;
                if (exp_kind.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL evt_unexpected: kind %0d col %0d, no event required", kind, evt_col);
                end else begin
                    k = exp_kind.pop_front();
                    c = exp_col.pop_front();
                    check("evt_kind", kind, k);
                    if (k != 2) check("evt_col", int'(evt_col), c);
                end
            end
        end
    end

    task automatic settle();
        repeat (2 * SLOTS + 8) @(negedge clk);
        check("exp_wr_drained", exp_addr.size(), 0);
        check("exp_evt_drained", exp_kind.size(), 0);
        check("hit_score", int'(hit_score), m_hit);
        check("miss_score", int'(miss_score), m_miss);
        check("key_ready_idle", int'(key_ready), 1);
        exp_addr.delete(); exp_data.delete();
        exp_kind.delete(); exp_col.delete();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!key_ready && n < SLOTS + 4) begin
            @(negedge clk);
            n++;
        end
        check("key_ready_rise", int'(key_ready), 1);
        check("key_latency_ok", int'(n <= SLOTS + 1), 1);
    endtask

    task automatic do_spawn(int ch, int col, int h);
        m_spawn(ch, col, h);
        spawn_tick = 1'b1;
        spawn_char = 8'(ch);
        spawn_col  = 7'(col);
        spawn_hits = 2'(h);
        @(negedge clk);
        spawn_tick = 1'b0;
        settle();
    endtask

    task automatic do_fall();
        m_fall();
        fall_tick = 1'b1;
        @(negedge clk);
        fall_tick = 1'b0;
        settle();
    endtask

    task automatic do_key(int code);
        m_key(code);
        key_valid = 1'b1;
        key_code  = 8'(code);
        @(negedge clk);
        key_valid = 1'b0;
        check("key_ready_fall", int'(key_ready), 0);
        wait_ready();
        settle();
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_wr_en"}, int'(wr_en), 0);
        check({tag, "_wr_addr"}, int'(wr_addr), 0);
        check({tag, "_wr_data"}, int'(wr_data), 0);
        check({tag, "_hit_score"}, int'(hit_score), 0);
        check({tag, "_miss_score"}, int'(miss_score), 0);
        check({tag, "_events"}, int'({hit_evt, miss_evt, spawn_drop}), 0);
        check({tag, "_evt_col"}, int'(evt_col), 0);
        check({tag, "_key_ready"}, int'(key_ready), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base, ds;
        int ea[6];
        int ed[6];
        rst = 1'b1;
        spawn_tick = 1'b0; spawn_char = '0; spawn_col = '0; spawn_hits = '0;
        fall_tick = 1'b0; key_valid = 1'b0; key_code = '0;
        m_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        checking = 1'b1;
        @(negedge clk);

        // spawn 'A' at column 5
        base = log_addr.size();
        do_spawn(8'h41, 5, 1);
        check("A_spawn_count", log_addr.size() - base, 1);
        if (log_addr.size() > base) begin
            check("A_spawn_addr", log_addr[base], 145);
            check("A_spawn_data", log_data[base], 'h141);
        end

        // three falls
        base = log_addr.size();
        ea = '{145, 215, 215, 285, 285, 355};
        ed = '{0, 'h141, 0, 'h141, 0, 'h141};
        repeat (3) do_fall();
        check("A_fall_count", log_addr.size() - base, 6);
        if (log_addr.size() >= base + 6)
            for (int i = 0; i < 6; i++) begin
                check("A_fall_addr", log_addr[base + i], ea[i]);
                check("A_fall_data", log_data[base + i], ed[i]);
            end

        // key 'A' retires it
        base = log_addr.size();
        do_key(8'h41);
        check("A_hit_count", log_addr.size() - base, 1);
        if (log_addr.size() > base) check("A_hit_addr", log_addr[base], 355);
        check("A_hit_evt_col", int'(evt_col), 5);
        check("A_hit_score", int'(hit_score), 1);

        // 'B' at column 0 falls past the bottom
        do_spawn(8'h42, 0, 1);
        repeat (BOTTOM_ROW - TOP_ROW + 1) do_fall();
        check("B_miss_last_addr", log_addr[log_addr.size() - 1], 1890);
        check("B_miss_last_data", log_data[log_addr.size() - 1], 0);
        check("B_miss_score", int'(miss_score), 1);
        check("B_miss_evt_col", int'(evt_col), 0);

`ifdef FCE_MULTI_HIT_EN
        base = log_addr.size();
        do_spawn(8'h43, 10, 3);
        repeat (3) do_key(8'h43);
        check("C_count", log_addr.size() - base, 4);
        if (log_addr.size() >= base + 4) begin
            check("C_spawn_data", log_data[base], 'h343);
            check("C_key1_data", log_data[base + 1], 'h243);
            check("C_key2_data", log_data[base + 2], 'h143);
            check("C_key3_data", log_data[base + 3], 0);
            check("C_key3_addr", log_addr[base + 3], 150);
        end
        check("C_hit_score", int'(hit_score), 2);
`endif

        // fill every slot, then one more spawn is dropped
        for (int i = 0; i < SLOTS; i++) do_spawn(97 + i % 26, i, 1);
        base = log_addr.size();
        ds = drop_seen;
        do_spawn(8'h5A, 40, 1);
        check("full_no_write", log_addr.size() - base, 0);
        check("full_drop", drop_seen - ds, 1);

        // drain the table at the bottom row
        repeat (BOTTOM_ROW - TOP_ROW + 1) do_fall();

        // column boundary
        ds = drop_seen;
        base = log_addr.size();
        do_spawn(8'h51, COLS, 2);
        check("col_limit_drop", drop_seen - ds, 1);
        check("col_limit_no_write", log_addr.size() - base, 0);
        do_spawn(8'h52, COLS - 1, 1);
        check("col_last_addr", log_addr[log_addr.size() - 1], 209);

        // simultaneous key, fall and spawn
        do_spawn(8'h58, 3, 1);
        base = log_addr.size();
        m_key(8'h58);
        m_fall();
        m_spawn(8'h59, 4, 1);
        key_valid = 1'b1; key_code = 8'h58;
        fall_tick = 1'b1;
        spawn_tick = 1'b1; spawn_char = 8'h59; spawn_col = 7'd4; spawn_hits = 2'd1;
        @(negedge clk);
        key_valid = 1'b0; fall_tick = 1'b0; spawn_tick = 1'b0;
        check("sim_key_ready_fall", int'(key_ready), 0);
        wait_ready();
        settle();
        check("sim_count", log_addr.size() - base, 4);
        if (log_addr.size() >= base + 4) begin
            check("sim_first_key", log_addr[base], 143);
            check("sim_last_spawn", log_addr[base + 3], 144);
        end

        // reset in the middle of a fall pass
        checking = 1'b0;
        fall_tick = 1'b1;
        @(negedge clk);
        fall_tick = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        m_reset();
        @(negedge clk);
        checking = 1'b1;
        do_spawn(8'h4D, 20, 1);
        do_fall();

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 4)
                do_spawn(65 + $urandom_range(0, 3), $urandom_range(0, COLS + 3), $urandom_range(0, 3));
            else if (sel < 7)
                do_fall();
            else
                do_key(65 + $urandom_range(0, 4));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
